// File: rtl/bcd_right_shift_seq.sv
// bcd_right_shift_seq
// Sequential right shifter for packed BCD operands, one digit position per clock.
// The first shift brings a caller-supplied digit in at the MSB and every later
// shift brings in zero. The block reports the last digit shifted out, and a
// sticky flag covering the digits shifted out before that one. Together these
// give the guard/sticky information needed for decimal rounding.
//
// Ports:
//   i_clk, i_rst_n   clock (rising edge) and asynchronous active-low reset
//   i_valid/o_ready  command handshake; i_num, i_digit and i_amt are sampled on accept
//   o_valid/i_ready  result handshake; o_num, o_digit and o_sticky are held while o_valid=1
//   i_num            operand, packed BCD, digit 0 in [3:0]
//   i_digit          digit inserted at the MSB on the first shift
//   i_amt            requested shift in digits (values above NUM_DIGITS+1 act as NUM_DIGITS+1)
//   o_num            shifted result
//   o_digit          last digit shifted out (weight 10^-1 of o_num)
//   o_sticky         OR of (digit != 0) over the digits shifted out before o_digit
//
// Optional build macro BCD_RSH_DIGIT_CHECK_EN adds o_err. o_err flags a non-BCD
// nibble in i_num or i_digit at accept. Shifting is not affected by it.
module bcd_right_shift_seq #(
  parameter int NUM_DIGITS = 4,
  parameter int AMT_W      = $clog2(NUM_DIGITS + 2)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [NUM_DIGITS*4-1:0] i_num,
  input  logic [3:0]              i_digit,
  input  logic [AMT_W-1:0]        i_amt,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [NUM_DIGITS*4-1:0] o_num,
  output logic [3:0]              o_digit,
  output logic                    o_sticky
`ifdef BCD_RSH_DIGIT_CHECK_EN
  ,
  output logic                    o_err
`endif
);

  localparam int NW = NUM_DIGITS * 4;
  localparam logic [AMT_W-1:0] AMT_MAX = AMT_W'(NUM_DIGITS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [NW-1:0]    sreg;
  logic [3:0]       fill;
  logic [AMT_W-1:0] cnt;
  logic [AMT_W-1:0] amt_eff;

  // True when any nibble of the operand or the fill digit is above 9.
  function automatic logic has_bad_digit(input logic [NW-1:0] num, input logic [3:0] dig);
    logic bad;
    bad = (dig > 4'd9);
    for (int k = 0; k < NUM_DIGITS; k++) begin
      bad = bad | (num[k*4 +: 4] > 4'd9);
    end
    return bad;
  endfunction

  // Shifting more than NUM_DIGITS+1 places only moves zeros, so clamp the count.
  always_comb begin
    if (i_amt > AMT_MAX) begin
      amt_eff = AMT_MAX;
    end else begin
      amt_eff = i_amt;
    end
  end

  assign o_num = sreg;

  // Control FSM and datapath. All outputs are registered.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      sreg     <= '0;
      fill     <= 4'd0;
      cnt      <= '0;
      o_digit  <= 4'd0;
      o_sticky <= 1'b0;
      o_valid  <= 1'b0;
      o_ready  <= 1'b1;
`ifdef BCD_RSH_DIGIT_CHECK_EN
      o_err    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            sreg     <= i_num;
            fill     <= i_digit;
            cnt      <= amt_eff;
            o_digit  <= 4'd0;
            o_sticky <= 1'b0;
            o_ready  <= 1'b0;
`ifdef BCD_RSH_DIGIT_CHECK_EN
            o_err    <= has_bad_digit(i_num, i_digit);
`endif
            // A zero-shift command still spends one cycle in DONE before
            // o_valid rises, so every command has a latency of at least one cycle.
            state <= (amt_eff == '0) ? DONE : SHIFT;
          end else begin
            o_ready <= 1'b1;
          end
        end
        SHIFT: begin
          o_sticky <= o_sticky | (o_digit != 4'd0);
          o_digit  <= sreg[3:0];
          sreg     <= {fill, sreg[NW-1:4]};
          fill     <= 4'd0;  // only the first shift inserts the caller's digit
          cnt      <= cnt - AMT_W'(1);
          if (cnt == AMT_W'(1)) begin
            state   <= DONE;
            o_valid <= 1'b1;
          end else begin
            state <= SHIFT;
          end
        end
        DONE: begin
          if (o_valid && i_ready) begin
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            state   <= IDLE;
          end else begin
            o_valid <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          o_valid <= 1'b0;
          o_ready <= 1'b1;
        end
      endcase
    end
  end

`ifndef BCD_RSH_DIGIT_CHECK_EN
  // The check helper is only used when the digit check is built in.
  logic unused_chk;
  assign unused_chk = has_bad_digit(sreg, fill);
`endif

endmodule

// File: doc/bcd_right_shift_seq.md
Name: bcd_right_shift_seq

Overview:
- Sequential BCD right shifter: shifts an NUM_DIGITS-digit packed BCD number right by a requested number of digit positions, one digit per clock.
- Inserts a carry-in digit at the MSB on the first shift. Reports the last digit shifted out and a sticky flag for digits below it.
- Sits in the calculator datapath for decimal scaling (divide by 10^n, alignment before add/sub, rounding).
- Valid/ready on both the command and result sides.

Parameters:
- NUM_DIGITS, 4, number of BCD digits in the operand.
- AMT_W, $clog2(NUM_DIGITS+2), width of the shift-amount input.

Ports:
- i_clk  input  1  clock, all state on rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_valid  input  1  command valid
- o_ready  output  1  block can accept a command
- i_num  input  NUM_DIGITS*4  operand, packed BCD, digit 0 in [3:0]
- i_digit  input  4  BCD digit shifted in at MSB on first shift
- i_amt  input  AMT_W  requested right shift in digits
- o_valid  output  1  result valid
- i_ready  input  1  result consumer ready
- o_num  output  NUM_DIGITS*4  shifted result
- o_digit  output  4  last digit shifted out (weight 10^-1 of o_num)
- o_sticky  output  1  OR of (digit != 0) over all digits shifted out before o_digit

Behaviour:
- Reset (async, i_rst_n=0):
  - State IDLE.
  - Shift register, o_digit, o_sticky, counter and o_valid all 0.
  - o_ready=1 once reset is released and the block is in IDLE.
  - Reset mid-operation aborts the operation; no result is produced.
- Effective amount: amt_eff = min(i_amt, NUM_DIGITS+1). Further shifts would only move zeros, so the result is identical.
- States:
  - IDLE:
    - o_ready=1, o_valid=0.
    - On i_valid&o_ready: load i_num into the shift register, latch i_digit as the fill digit, clear o_digit and o_sticky, load the counter with amt_eff.
    - Next state is DONE if amt_eff=0, otherwise SHIFT.
  - SHIFT:
    - o_ready=0, o_valid=0.
    - Each cycle: sticky <= sticky | (o_digit != 0); o_digit <= reg[3:0]; reg <= {fill, reg[top:4]}.
    - fill is the latched i_digit on the first shift and 0 on every later shift.
    - Counter decrements each cycle; after the last shift (counter 1 to 0) go to DONE.
  - DONE:
    - o_valid=1; o_num, o_digit and o_sticky are held stable.
    - On i_ready go to IDLE. Otherwise stay and hold.
- Latency: o_valid rises max(amt_eff,1) cycles after the accept edge.
- Throughput: one command per (latency + 2) cycles minimum.
- o_ready is asserted only in IDLE; there is no overlap with DONE.
- Inputs are sampled only on the accept edge. Changes during SHIFT/DONE have no effect.
- o_num/o_digit/o_sticky are don't-care while o_valid=0, but must be 0 after reset.
- Digits are moved, not validated; non-BCD nibbles pass through unchanged. Optional check below.
- amt_eff = NUM_DIGITS+1 gives o_num=0, o_digit = latched i_digit, o_sticky = OR of all nonzero i_num digits.

Optional Feature:
- Macro: BCD_RSH_DIGIT_CHECK_EN
- Defined:
  - Adds port o_err (output, 1): registered at accept, set if any nibble of i_num or i_digit is > 9.
  - o_err is presented with o_valid, held through DONE, cleared on reset and on the next accept.
  - Shifting proceeds normally regardless of o_err.
- Undefined: no o_err port, no check logic.

Test Plan:
- i_num=0x1234, i_digit=5, i_amt=1, i_ready=1 -> o_valid after 1 cycle; o_num=0x5123, o_digit=4, o_sticky=0; o_ready back high 1 cycle after handshake.
- i_num=0x1234, i_digit=0, i_amt=2 -> o_valid after 2 cycles; o_num=0x0012, o_digit=3, o_sticky=1.
- i_num=0x9876, i_digit=7, i_amt=0 -> o_valid after 1 cycle; o_num=0x9876, o_digit=0, o_sticky=0; digit 7 not inserted.
- i_num=0x1234, i_digit=9, i_amt=7 -> clamps to 5 shifts, o_valid after 5 cycles; o_num=0x0000, o_digit=9, o_sticky=1.
- Result for i_num=0x1000, i_amt=3 with i_ready held low 4 cycles:
  - Outputs stay o_num=0x0001, o_digit=0, o_sticky=0 and o_valid stays high.
  - o_ready stays low and i_valid pulses are ignored.
  - Reset asserted during a later SHIFT gives o_valid=0, o_ready=1, and all outputs 0 immediately.
- With BCD_RSH_DIGIT_CHECK_EN: i_num=0x12A4, i_amt=1 -> o_err=1, o_num=0x012A, o_digit=4; next command i_num=0x0009 -> o_err=0.
